// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel result-channel packer.
package sobel_pkg;

    localparam int unsigned CH_W           = 8;
    localparam int unsigned PIX_W          = 3 * CH_W;
    localparam int unsigned IMG_W_DEF      = 512;
    localparam int unsigned IMG_H_DEF      = 512;
    localparam int unsigned FIFO_DEPTH_DEF = 2;

    typedef logic [CH_W-1:0] ch_t;

    typedef struct packed {
        ch_t b;
        ch_t g;
        ch_t r;
    } pix_t;

    function automatic pix_t pack_pix(input ch_t r, input ch_t g, input ch_t b);
        pix_t p;
        p.b = b;
        p.g = g;
        p.r = r;
        return p;
    endfunction

endpackage

// File: rtl/sobel_ch_fifo.sv
// Per-channel elastic buffer: registered count, registered full flag,
// combinational head read. Push is refused while full, even with a pop.
module sobel_ch_fifo
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  ch_t  i_data,
    input  logic i_pop,
    output ch_t  o_data_c,
    output logic o_full,
    output logic o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    ch_t           r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic [CW-1:0] w_count_nxt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count  <= '0;
            r_full   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data_c  = r_mem[r_rd_ptr];
    assign o_empty_c = (r_count == '0);
    assign o_full    = r_full;

endmodule

// File: rtl/sobel_rgb_packer.sv
// Re-joins the r/g/b Sobel result channels into one packed pixel stream
// tagged with end-of-line / end-of-frame markers.
module sobel_rgb_packer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W      = IMG_W_DEF,
    parameter int unsigned IMG_H      = IMG_H_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_result_r_vld,
    output logic             i_result_r_busy,
    input  logic [CH_W-1:0]  i_result_r_data,
    input  logic             i_result_g_vld,
    output logic             i_result_g_busy,
    input  logic [CH_W-1:0]  i_result_g_data,
    input  logic             i_result_b_vld,
    output logic             i_result_b_busy,
    input  logic [CH_W-1:0]  i_result_b_data,
    output logic             o_pix_vld,
    input  logic             o_pix_busy,
    output logic [PIX_W-1:0] o_pix_data,
    output logic             o_pix_eol,
    output logic             o_pix_eof
);

    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    ch_t           w_r_data;
    ch_t           w_g_data;
    ch_t           w_b_data;
    logic          w_r_empty;
    logic          w_g_empty;
    logic          w_b_empty;
    logic          w_join;
    logic          w_eol;
    logic          w_eof;

    pix_t          r_pix;
    logic          r_pix_vld;
    logic          r_pix_eol;
    logic          r_pix_eof;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    sobel_ch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_r (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (i_result_r_vld),
        .i_data    (i_result_r_data),
        .i_pop     (w_join),
        .o_data_c  (w_r_data),
        .o_full    (i_result_r_busy),
        .o_empty_c (w_r_empty)
    );

    sobel_ch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_g (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (i_result_g_vld),
        .i_data    (i_result_g_data),
        .i_pop     (w_join),
        .o_data_c  (w_g_data),
        .o_full    (i_result_g_busy),
        .o_empty_c (w_g_empty)
    );

    sobel_ch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (i_result_b_vld),
        .i_data    (i_result_b_data),
        .i_pop     (w_join),
        .o_data_c  (w_b_data),
        .o_full    (i_result_b_busy),
        .o_empty_c (w_b_empty)
    );

    // A pixel is formed only when every channel has data and the output slot frees up.
    assign w_join = !w_r_empty && !w_g_empty && !w_b_empty && (!r_pix_vld || !o_pix_busy);
    assign w_eol  = (r_x == X_LAST);
    assign w_eof  = w_eol && (r_y == Y_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pix     <= '0;
            r_pix_vld <= 1'b0;
            r_pix_eol <= 1'b0;
            r_pix_eof <= 1'b0;
        end else if (w_join) begin
            r_pix     <= pack_pix(w_r_data, w_g_data, w_b_data);
            r_pix_vld <= 1'b1;
            r_pix_eol <= w_eol;
            r_pix_eof <= w_eof;
        end else if (r_pix_vld && !o_pix_busy) begin
            r_pix_vld <= 1'b0;
        end
    end

    // Position tracks formed pixels, so markers are fixed at load time.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_join) begin
            if (w_eol) begin
                r_x <= '0;
                r_y <= w_eof ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_pix_vld  = r_pix_vld;
    assign o_pix_data = r_pix;
    assign o_pix_eol  = r_pix_eol;
    assign o_pix_eof  = r_pix_eof;

endmodule

// File: tb/tb_sobel_rgb_packer.sv
// Directed bench for sobel_rgb_packer on a 4x3 frame with 2-deep channel FIFOs.
module tb_sobel_rgb_packer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int D = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [2:0]  ch_vld;
    logic [7:0]  ch_data [3];
    logic        r_busy, g_busy, b_busy;
    logic [2:0]  ch_busy;
    logic        o_pix_vld, o_pix_busy, o_pix_eol, o_pix_eof;
    logic [23:0] o_pix_data;

    logic [2:0]  acc;
    logic [23:0] sb [$];
    logic [24:0] snap;
    int          sent [3];
    int          total [3];
    int          start [3];
    int          cyc, first_vld, hold_lo, hold_hi;
    int          out_cnt, eol_cnt, eof_cnt, pos;
    bit          busy_seen;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 i_clk = ~i_clk;

    assign ch_busy = {b_busy, g_busy, r_busy};

    sobel_rgb_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_result_r_vld  (ch_vld[0]),
        .i_result_r_busy (r_busy),
        .i_result_r_data (ch_data[0]),
        .i_result_g_vld  (ch_vld[1]),
        .i_result_g_busy (g_busy),
        .i_result_g_data (ch_data[1]),
        .i_result_b_vld  (ch_vld[2]),
        .i_result_b_busy (b_busy),
        .i_result_b_data (ch_data[2]),
        .o_pix_vld       (o_pix_vld),
        .o_pix_busy      (o_pix_busy),
        .o_pix_data      (o_pix_data),
        .o_pix_eol       (o_pix_eol),
        .o_pix_eof       (o_pix_eof)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int n);
        logic [7:0] r, g, b;
        r = 8'(n);
        g = 8'(2 * n);
        b = 8'(3 * n);
        return {b, g, r};
    endfunction

    // Which channel transfers happened at the last edge.
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) acc <= '0;
        else        acc <= ch_vld & ~ch_busy;
    end

    // Output scoreboard: checked just before each accepting edge.
    always @(negedge i_clk) begin
        if (i_rst && o_pix_vld && !o_pix_busy) begin
            if (sb.size() == 0) begin
                check("unexpected_pix", {8'h0, o_pix_data}, 32'hFFFF_FFFF);
            end else begin
                check("pix_data", {8'h0, o_pix_data}, {8'h0, sb.pop_front()});
                check("pix_eol", 32'(o_pix_eol), 32'((pos % W) == W - 1));
                check("pix_eof", 32'(o_pix_eof), 32'((pos % (W * H)) == W * H - 1));
            end
            if (o_pix_eol) eol_cnt++;
            if (o_pix_eof) eof_cnt++;
            pos++;
            out_cnt++;
        end
    end

    task automatic setup(input int n, input int s0, input int s1, input int s2);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(exp_pix(i));
        for (int c = 0; c < 3; c++) begin
            total[c] = n;
            sent[c]  = 0;
        end
        start[0] = s0; start[1] = s1; start[2] = s2;
        cyc = 0; first_vld = -1; hold_lo = -1; hold_hi = -1;
        out_cnt = 0; eol_cnt = 0; eof_cnt = 0; pos = 0; busy_seen = 1'b0;
    endtask

    task automatic step();
        for (int c = 0; c < 3; c++) sent[c] += int'(acc[c]);
        for (int c = 0; c < 3; c++) begin
            if (cyc >= start[c] && sent[c] < total[c]) begin
                ch_vld[c]  = 1'b1;
                ch_data[c] = 8'((c + 1) * sent[c]);
            end else begin
                ch_vld[c]  = 1'b0;
            end
        end
        if (cyc == hold_lo) snap = {o_pix_vld, o_pix_data};
        o_pix_busy = (cyc >= hold_lo && cyc <= hold_hi);
        @(posedge i_clk);
        #1;
        if (o_pix_vld && first_vld < 0) first_vld = cyc;
        if (r_busy) busy_seen = 1'b1;
        if (cyc >= hold_lo && cyc <= hold_hi) check("bp_hold", 32'(snap), {7'h0, o_pix_vld, o_pix_data});
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0 && !o_pix_vld) break;
            step();
        end
        check("drain_done", 32'(sb.size() == 0 && !o_pix_vld), 32'd1);
        ch_vld = '0;
    endtask

    task automatic do_reset();
        ch_vld     = '0;
        o_pix_busy = 1'b0;
        i_rst      = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b0;
        ch_vld = '0;
        o_pix_busy = 1'b0;
        for (int c = 0; c < 3; c++) ch_data[c] = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_vld",    32'(o_pix_vld), 32'd0);
        check("rst_data",   {8'h0, o_pix_data}, 32'd0);
        check("rst_eol",    32'(o_pix_eol), 32'd0);
        check("rst_eof",    32'(o_pix_eof), 32'd0);
        check("rst_busy",   32'(ch_busy), 32'd0);
        i_rst = 1'b1;

        // Aligned streaming: 2-cycle latency, one pixel per cycle.
        do_reset();
        setup(8, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) check("al_lat_vld0", 32'(o_pix_vld), 32'd0);
            if (k == 1) check("al_first_vld", 32'(o_pix_vld), 32'd1);
            if (k == 1) check("al_first_data", {8'h0, o_pix_data}, 32'h000000);
            if (k == 2) check("al_second_data", {8'h0, o_pix_data}, 32'h030201);
        end
        check("al_thru", 32'(out_cnt), 32'd8);
        drain(20);

        // Skew: g lags r by 3, b lags r by 5.
        do_reset();
        setup(8, 0, 3, 5);
        drain(60);
        check("sk_first", 32'(first_vld), 32'd6);
        check("sk_rbusy_seen", 32'(busy_seen), 32'd1);
        check("sk_rbusy_end", 32'(r_busy), 32'd0);
        check("sk_count", 32'(out_cnt), 32'd8);

        // Backpressure held for 10 cycles mid-stream.
        do_reset();
        setup(12, 0, 0, 0);
        hold_lo = 4;
        hold_hi = 13;
        for (int k = 0; k < 14; k++) begin
            step();
            if (k == 4)  check("bp_vld", 32'(o_pix_vld), 32'd1);
            if (k == 13) check("bp_all_busy", 32'(ch_busy), 32'd7);
        end
        drain(60);
        check("bp_count", 32'(out_cnt), 32'd12);

        // Markers across two 4x3 frames.
        do_reset();
        setup(24, 0, 0, 0);
        drain(80);
        check("mk_count", 32'(out_cnt), 32'd24);
        check("mk_eol_cnt", 32'(eol_cnt), 32'd6);
        check("mk_eof_cnt", 32'(eof_cnt), 32'd2);

        // Asynchronous reset mid-row with FIFOs partly filled.
        do_reset();
        setup(12, 0, 0, 2);
        for (int k = 0; k < 40 && out_cnt < 5; k++) step();
        check("rs_reach5", 32'(out_cnt >= 5), 32'd1);
        #2;
        i_rst = 1'b0;
        #1;
        check("rs_vld", 32'(o_pix_vld), 32'd0);
        check("rs_busy", 32'(ch_busy), 32'd0);
        check("rs_eol", 32'(o_pix_eol), 32'd0);
        ch_vld = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        setup(4, 0, 0, 0);
        drain(30);
        check("rs_count", 32'(out_cnt), 32'd4);
        check("rs_eol_cnt", 32'(eol_cnt), 32'd1);
        check("rs_eof_cnt", 32'(eof_cnt), 32'd0);

        // Missing b channel, then b arrives.
        do_reset();
        setup(D, 0, 0, 1000);
        for (int k = 0; k < 6; k++) begin
            step();
            check("mc_no_vld", 32'(o_pix_vld), 32'd0);
        end
        check("mc_r_busy", 32'(r_busy), 32'd1);
        check("mc_g_busy", 32'(g_busy), 32'd1);
        check("mc_b_busy", 32'(b_busy), 32'd0);
        check("mc_r_sent", 32'(sent[0]), 32'(D));
        start[2] = 0;
        drain(30);
        check("mc_count", 32'(out_cnt), 32'(D));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_rgb_packer.md
Name: sobel_rgb_packer

Overview:
- Downstream consumer of the Sobel filter's three independent 8-bit result channels (r, g, b), each with its own vld/busy handshake.
- Re-joins the three channels into one packed 24-bit pixel stream with the same vld/busy protocol.
- Tags each pixel with end-of-line and end-of-frame markers for the 512-wide row batch.
- Feeds the output writer / DMA stage.

Parameters:
- IMG_W, 512, pixels per row
- IMG_H, 512, rows per frame
- FIFO_DEPTH, 2, entries per channel FIFO (power of two, >=2)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous active-low reset
- i_result_r_vld  in  1  r channel data valid
- i_result_r_busy  out  1  r channel backpressure
- i_result_r_data  in  8  r value
- i_result_g_vld  in  1  g channel data valid
- i_result_g_busy  out  1  g channel backpressure
- i_result_g_data  in  8  g value
- i_result_b_vld  in  1  b channel data valid
- i_result_b_busy  out  1  b channel backpressure
- i_result_b_data  in  8  b value
- o_pix_vld  out  1  packed pixel valid
- o_pix_busy  in  1  downstream backpressure
- o_pix_data  out  24  packed pixel: b[23:16], g[15:8], r[7:0]
- o_pix_eol  out  1  pixel is last of row (valid with o_pix_vld)
- o_pix_eof  out  1  pixel is last of frame (valid with o_pix_vld)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous, active-low.
- Transfer rule (all interfaces): a transfer occurs on a rising edge where vld=1 and busy=0. A producer holds data stable while vld=1 and busy=1.
- Reset values:
  - i_result_*_busy = 0
  - o_pix_vld = 0, o_pix_data = 0, o_pix_eol = 0, o_pix_eof = 0
  - FIFOs empty
  - x and y counters = 0
- Channel FIFOs:
  - One FIFO per channel, FIFO_DEPTH entries, registered occupancy count.
  - i_result_c_busy = (count == FIFO_DEPTH), a registered value.
  - No push-through on a full FIFO. A push and a pop in the same cycle on a non-full FIFO are both performed; count is unchanged.
- Join condition: join = all three FIFOs non-empty AND (o_pix_vld == 0 OR o_pix_busy == 0).
- On join:
  - Pop one entry from each FIFO.
  - Load the output register with {b, g, r}.
  - Set o_pix_vld = 1.
  - Compute eol/eof from the counters for this pixel.
- Output register hold/clear:
  - o_pix_vld=1 and o_pix_busy=1: hold data, eol and eof unchanged.
  - Output transfers and no join: o_pix_vld drops to 0.
- Pixel ordering: the channels may arrive skewed by any number of cycles. Pixels are paired strictly in per-channel arrival order; no reordering.
- Latency: a pixel is visible on o_pix_* 2 cycles after the last of its three channel values is accepted (1 cycle FIFO registration, 1 cycle output register), provided the output stage is free.
- Throughput: 1 pixel/cycle when all channels stream and o_pix_busy=0.
- Position counters: x (0..IMG_W-1) and y (0..IMG_H-1) advance on each join, not on output transfer.
  - o_pix_eol = (x == IMG_W-1) for the loaded pixel.
  - o_pix_eof = eol AND (y == IMG_H-1).
  - x wraps to 0 after IMG_W-1 and y increments.
  - y wraps to 0 after the eof pixel; the next frame starts at (0,0) with no idle cycle.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H) bits.
- Reset mid-frame: everything is discarded immediately (asynchronous). The FIFOs empty, the counters go to (0,0), and o_pix_vld drops to 0 without waiting for the clock.
- Partial data: if one channel never delivers, the other channels fill their FIFOs and assert busy. No output is produced and no state is corrupted.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W=24, CH_W=8
  - IMG_W/IMG_H default constants
  - packed pixel typedef {b, g, r}
- One sub-module: sobel_ch_fifo (8-bit, FIFO_DEPTH, push/pop/full/empty, registered count), instantiated three times.
- The join, output register and counters live in the top.

Test Plan:
- Aligned streaming: r=g=b vld every cycle with values n, 2n, 3n (mod 256), o_pix_busy=0 → one output per cycle after 2-cycle latency; o_pix_data = {3n,2n,n}; first pixel data 0x000000, second 0x030201.
- Skew: r leads g by 3 cycles and b by 5 cycles, 8 pixels → outputs in order with correct pairing. The first output appears 2 cycles after b's first transfer. The r FIFO fills and i_result_r_busy asserts, then deasserts as data drains.
- Backpressure: hold o_pix_busy=1 for 10 cycles mid-stream → o_pix_data and o_pix_vld stay stable. All three input busys assert once the FIFOs are full. No pixel is lost or duplicated after release (checked by scoreboard).
- Markers with IMG_W=4, IMG_H=3: stream 24 pixels → o_pix_eol on pixels 3,7,11,...; o_pix_eof on pixels 11 and 23; the second frame restarts at x=0,y=0.
- Reset mid-frame: pull i_rst low during pixel 5 of a row with FIFOs partially full → o_pix_vld=0 and all busys=0 asynchronously. After release, 4 fresh pixels produce eol on the 4th (IMG_W=4).
- Missing channel: drive only r and g for 6 cycles → no o_pix_vld. r/g busy after FIFO_DEPTH transfers. Then send b → FIFO_DEPTH pixels emerge correctly paired.
